// File: rtl/rv_pkg.sv
// Shared definitions for the writeback slice of the sequential core.
//  - funct3 encodings of the load instructions (F3_LB .. F3_LHU)
//  - writeback FSM state encoding
//  - load_fault(): flags illegal load widths and misaligned addresses
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

  // A load is rejected before reaching memory if its width encoding is not
  // one of the five legal loads, or if the address is not naturally aligned
  // for that width.
  function automatic logic load_fault(input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic fault_s;
    case (funct3)
      F3_LB, F3_LBU: fault_s = 1'b0;
      F3_LH, F3_LHU: fault_s = addr_lo[0];
      F3_LW:         fault_s = (addr_lo != 2'b00);
      default:       fault_s = 1'b1;
    endcase
    return fault_s;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane extraction for loads.
// Ports:
//  rdata    in  32  little-endian word returned by data memory
//  addr_lo  in  2   byte offset of the load address
//  funct3   in  3   load width/sign
//  value    out 32  extended value for the register file
// Bytes are picked by addr_lo, halves by addr_lo[1]; LB/LH sign-extend,
// LBU/LHU zero-extend, LW passes the word through.
module load_extend (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);
  import rv_pkg::*;

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword lanes.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected lane according to the load kind.
  always_comb begin
    value = 32'h0000_0000;
    case (funct3)
      F3_LB:   value = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  value = {24'h00_0000, byte_s};
      F3_LH:   value = {{16{half_s[15]}}, half_s};
      F3_LHU:  value = {16'h0000, half_s};
      F3_LW:   value = rdata;
      default: value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires one op from Execute into the Decode register file.
// ALU ops are written the cycle after acceptance; loads go through a
// req/ack data-memory read first, with lane extraction by load_extend.
// Ports:
//  clk, rst_n                       clock, async active-low reset
//  in_valid/in_ready                op handshake from Execute (ready only in IDLE)
//  in_rd, in_funct3, in_MemRead,
//  in_RegWrite, in_alu_result       op fields; alu_result is the load address
//  mem_req/mem_addr/mem_ack/mem_rdata   data-memory read port
//  reg_write_data, RegWrite, rd_out register-file write port
//  wb_done, err_misalign, err_timeout   retirement pulses
// Parameter TIMEOUT: MEM_WAIT cycles without ack before abort (0 = wait forever).
module writeback_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic        in_MemRead,
  input  logic        in_RegWrite,
  input  logic [31:0] in_alu_result,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] reg_write_data,
  output logic        RegWrite,
  output logic [4:0]  rd_out,
  output logic        wb_done,
  output logic        err_misalign,
  output logic        err_timeout
);
  import rv_pkg::*;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  wb_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       rd_r;
  logic [2:0]       funct3_r;
  logic [1:0]       addr_lo_r;
  logic             regwrite_r;
  logic [31:0]      ext_s;
  logic             accept_s;
  logic             timeout_hit_s;

  assign accept_s      = in_valid && in_ready;
  // The counter holds the number of ack-less cycles already spent, so the
  // abort fires at the end of the TIMEOUT-th MEM_WAIT cycle.
  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_r == CNT_LAST);

  load_extend u_load_extend (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_r),
    .funct3  (funct3_r),
    .value   (ext_s)
  );

  // Writeback FSM with capture registers, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      rd_r           <= 5'd0;
      funct3_r       <= 3'd0;
      addr_lo_r      <= 2'd0;
      regwrite_r     <= 1'b0;
      in_ready       <= 1'b1;
      mem_req        <= 1'b0;
      mem_addr       <= 32'h0000_0000;
      reg_write_data <= 32'h0000_0000;
      RegWrite       <= 1'b0;
      rd_out         <= 5'd0;
      wb_done        <= 1'b0;
      err_misalign   <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            rd_r       <= in_rd;
            funct3_r   <= in_funct3;
            addr_lo_r  <= in_alu_result[1:0];
            regwrite_r <= in_RegWrite;
            in_ready   <= 1'b0;
            if (!in_MemRead) begin
              state_r        <= ST_WRITE;
              reg_write_data <= in_alu_result;
              RegWrite       <= in_RegWrite && (in_rd != 5'd0);
              rd_out         <= in_rd;
              wb_done        <= 1'b1;
            end else if (load_fault(in_funct3, in_alu_result[1:0])) begin
              // Rejected load: retire with an error, memory is never touched.
              state_r        <= ST_WRITE;
              reg_write_data <= 32'h0000_0000;
              RegWrite       <= 1'b0;
              rd_out         <= in_rd;
              wb_done        <= 1'b1;
              err_misalign   <= 1'b1;
            end else begin
              state_r  <= ST_MEM_WAIT;
              mem_req  <= 1'b1;
              mem_addr <= {in_alu_result[31:2], 2'b00};
              cnt_r    <= '0;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack) begin
            state_r        <= ST_WRITE;
            mem_req        <= 1'b0;
            reg_write_data <= ext_s;
            RegWrite       <= regwrite_r && (rd_r != 5'd0);
            rd_out         <= rd_r;
            wb_done        <= 1'b1;
          end else if (timeout_hit_s) begin
            state_r        <= ST_WRITE;
            mem_req        <= 1'b0;
            reg_write_data <= 32'h0000_0000;
            RegWrite       <= 1'b0;
            rd_out         <= rd_r;
            wb_done        <= 1'b1;
            err_timeout    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          state_r      <= ST_IDLE;
          in_ready     <= 1'b1;
          RegWrite     <= 1'b0;
          wb_done      <= 1'b0;
          err_misalign <= 1'b0;
          err_timeout  <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          in_ready     <= 1'b1;
          mem_req      <= 1'b0;
          RegWrite     <= 1'b0;
          wb_done      <= 1'b0;
          err_misalign <= 1'b0;
          err_timeout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (TIMEOUT=4) with a retirement scoreboard.
module tb_writeback_unit;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic        in_MemRead = 1'b0;
  logic        in_RegWrite = 1'b0;
  logic [31:0] in_alu_result = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] reg_write_data;
  logic        RegWrite;
  logic [4:0]  rd_out;
  logic        wb_done;
  logic        err_misalign;
  logic        err_timeout;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  writeback_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_funct3(in_funct3), .in_MemRead(in_MemRead),
    .in_RegWrite(in_RegWrite), .in_alu_result(in_alu_result),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_write_data(reg_write_data), .RegWrite(RegWrite), .rd_out(rd_out),
    .wb_done(wb_done), .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Pops the oldest expected retirement and compares it with the write port.
  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_wb", 32'(wb_done), 32'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_regwrite", 32'(RegWrite), 32'(e.rw));
      chk("sb_rd", 32'(rd_out), 32'(e.rd));
      chk("sb_misalign", 32'(err_misalign), 32'(e.mis));
      chk("sb_timeout", 32'(err_timeout), 32'(e.tmo));
      if (!e.mis && !e.tmo) chk("sb_data", reg_write_data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (wb_done === 1'b1) sb_check();
  end

  // Called at a negedge; presents one op for one edge and returns at the next negedge.
  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic mr,
                       input logic rw, input logic [31:0] addr, input exp_t e);
    in_rd = rd; in_funct3 = f3; in_MemRead = mr; in_RegWrite = rw; in_alu_result = addr;
    in_valid = 1'b1;
    chk("issue_ready", 32'(in_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_wb_done", 32'(wb_done), 32'd0);
    chk("rst_data", reg_write_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ALU op written one cycle after acceptance
    issue(5'd5, 3'b000, 1'b0, 1'b1, 32'h0000_1234, '{1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0});
    chk("alu_regwrite", 32'(RegWrite), 32'd1);
    chk("alu_data", reg_write_data, 32'h0000_1234);
    chk("alu_rd", 32'(rd_out), 32'd5);
    chk("alu_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("alu_strobe_off", 32'(RegWrite), 32'd0);
    chk("alu_ready_back", 32'(in_ready), 32'd1);

    // 2: LB at 0x103, ack three cycles later
    issue(5'd7, 3'b000, 1'b1, 1'b1, 32'h0000_0103, '{1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0});
    chk("lb_req", 32'(mem_req), 32'd1);
    chk("lb_addr", mem_addr, 32'h0000_0100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lb_req_held", 32'(mem_req), 32'd1);
      chk("lb_no_write", 32'(RegWrite), 32'd0);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("lb_req_drop", 32'(mem_req), 32'd0);
    chk("lb_data", reg_write_data, 32'hFFFF_FF80);
    @(negedge clk);

    // 3: LHU / LH at 0x102 with ack in the first wait cycle
    issue(5'd9, 3'b101, 1'b1, 1'b1, 32'h0000_0102, '{1'b1, 5'd9, 32'h0000_8001, 1'b0, 1'b0});
    mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("lhu_data", reg_write_data, 32'h0000_8001);
    @(negedge clk);
    issue(5'd10, 3'b001, 1'b1, 1'b1, 32'h0000_0102, '{1'b1, 5'd10, 32'hFFFF_8001, 1'b0, 1'b0});
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("lh_data", reg_write_data, 32'hFFFF_8001);
    @(negedge clk);

    // 4: rejected loads never request memory
    issue(5'd3, 3'b010, 1'b1, 1'b1, 32'h0000_0101, '{1'b0, 5'd3, 32'h0, 1'b1, 1'b0});
    chk("mis_lw_req", 32'(mem_req), 32'd0);
    chk("mis_lw_done", 32'(wb_done), 32'd1);
    chk("mis_lw_err", 32'(err_misalign), 32'd1);
    chk("mis_lw_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk);
    issue(5'd4, 3'b011, 1'b1, 1'b1, 32'h0000_0100, '{1'b0, 5'd4, 32'h0, 1'b1, 1'b0});
    chk("bad_f3_req", 32'(mem_req), 32'd0);
    chk("bad_f3_err", 32'(err_misalign), 32'd1);
    @(negedge clk);
    issue(5'd4, 3'b001, 1'b1, 1'b1, 32'h0000_0105, '{1'b0, 5'd4, 32'h0, 1'b1, 1'b0});
    chk("mis_lh_err", 32'(err_misalign), 32'd1);
    @(negedge clk);

    // 5: timeout after four request cycles; late ack ignored
    issue(5'd4, 3'b010, 1'b1, 1'b1, 32'h0000_0200, '{1'b0, 5'd4, 32'h0, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req", 32'(mem_req), 32'd1);
      chk("tmo_not_done", 32'(wb_done), 32'd0);
      @(negedge clk);
    end
    chk("tmo_err", 32'(err_timeout), 32'd1);
    chk("tmo_done", 32'(wb_done), 32'd1);
    chk("tmo_req_drop", 32'(mem_req), 32'd0);
    chk("tmo_regwrite", 32'(RegWrite), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_ack_regwrite", 32'(RegWrite), 32'd0);
    chk("late_ack_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("late_ack_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);

    // 6: async reset during a load, then normal ops and rd=0
    issue(5'd6, 3'b010, 1'b1, 1'b1, 32'h0000_0300, '{1'b1, 5'd6, 32'h0, 1'b0, 1'b0});
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(5'd10, 3'b000, 1'b0, 1'b1, 32'hCAFE_F00D, '{1'b1, 5'd10, 32'hCAFE_F00D, 1'b0, 1'b0});
    chk("post_rst_regwrite", 32'(RegWrite), 32'd1);
    chk("post_rst_data", reg_write_data, 32'hCAFE_F00D);
    @(negedge clk);
    issue(5'd0, 3'b000, 1'b0, 1'b1, 32'h0000_0055, '{1'b0, 5'd0, 32'h0000_0055, 1'b0, 1'b0});
    chk("rd0_done", 32'(wb_done), 32'd1);
    chk("rd0_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk);
    issue(5'd0, 3'b100, 1'b1, 1'b1, 32'h0000_0400, '{1'b0, 5'd0, 32'h0000_00A5, 1'b0, 1'b0});
    chk("rd0_load_req", 32'(mem_req), 32'd1);
    chk("rd0_load_addr", mem_addr, 32'h0000_0400);
    mem_ack = 1'b1; mem_rdata = 32'h0000_00A5;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rd0_load_done", 32'(wb_done), 32'd1);
    chk("rd0_load_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
